// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with req/ack data-memory access, timeout abort and load extension
// Ports:
//   clk_Mem, rst_Mem (sync, active-low)
//   *_in_Mem        : instruction fields from EX/MEM
//   dmem_*          : registered request to data memory; dmem_ack/dmem_rdata back
//   stall_Mem       : freezes upstream stages while an access is outstanding
//   misalign_Mem    : pulse after a misaligned or illegal-funct3 access
//   bus_err_Mem     : pulse after an access aborted on timeout
//   *_out_Mem       : fields towards MEM/WB, valid/RegWrite gated on stall/abort/fault
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_Mem,
   input  logic        rst_Mem,
   input  logic        valid_in_Mem,
   input  logic [31:0] PC_in_Mem,
   input  logic [31:0] inst_in_Mem,
   input  logic [31:0] PC4_in_Mem,
   input  logic [4:0]  Rd_addr_in_Mem,
   input  logic [31:0] ALU_in_Mem,
   input  logic [31:0] Rs2_data_in_Mem,
   input  logic        MemRead_in_Mem,
   input  logic        MemWrite_in_Mem,
   input  logic [2:0]  funct3_in_Mem,
   input  logic [1:0]  MemtoReg_in_Mem,
   input  logic        RegWrite_in_Mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_Mem,
   output logic        misalign_Mem,
   output logic        bus_err_Mem,
   output logic [31:0] PC_out_Mem,
   output logic [31:0] inst_out_Mem,
   output logic [31:0] PC4_out_Mem,
   output logic [4:0]  Rd_addr_out_Mem,
   output logic [31:0] ALU_out_Mem,
   output logic [1:0]  MemtoReg_out_Mem,
   output logic [31:0] Dmem_data_out_Mem,
   output logic        RegWrite_out_Mem,
   output logic        valid_out_Mem
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_n;
   logic [2:0] f3_q;
   logic [1:0] a_q;
   logic [7:0] cnt;
   logic mem_op, legal, bad, issue, ack, tmo, kill;
   logic is_byte, is_half;
   logic [7:0] lb;
   logic [15:0] lh;
   assign PC_out_Mem = PC_in_Mem;
   assign inst_out_Mem = inst_in_Mem;
   assign PC4_out_Mem = PC4_in_Mem;
   assign Rd_addr_out_Mem = Rd_addr_in_Mem;
   assign ALU_out_Mem = ALU_in_Mem;
   assign MemtoReg_out_Mem = MemtoReg_in_Mem;
   always_comb begin
      mem_op = valid_in_Mem & (MemRead_in_Mem | MemWrite_in_Mem);
      is_byte = funct3_in_Mem[1:0] == 2'b00;
      is_half = funct3_in_Mem[1:0] == 2'b01;
      // stores allow only 000..010; loads additionally allow the unsigned 100/101
      legal = MemWrite_in_Mem ? (!funct3_in_Mem[2] && funct3_in_Mem[1:0] != 2'b11)
                              : (funct3_in_Mem[1:0] != 2'b11 && funct3_in_Mem != 3'b110);
      bad = state == IDLE && mem_op && (!legal || (is_half && ALU_in_Mem[0])
            || (funct3_in_Mem[1:0] == 2'b10 && ALU_in_Mem[1:0] != 2'b00));
      issue = state == IDLE && mem_op && !bad;
      ack = state == WAIT && dmem_ack;
      tmo = state == WAIT && !dmem_ack && cnt == 8'(TIMEOUT - 1);
      state_n = issue ? WAIT : (ack || tmo) ? IDLE : state;
      stall_Mem = issue || (state == WAIT && !dmem_ack && !tmo);
      kill = stall_Mem || bad || tmo;
      valid_out_Mem = valid_in_Mem && !kill;
      RegWrite_out_Mem = RegWrite_in_Mem && !kill;
      lb = dmem_rdata[{a_q, 3'b000} +: 8];
      lh = a_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      // f3_q[2] marks the unsigned load variants
      Dmem_data_out_Mem = !ack ? 32'h0 : f3_q[1] ? dmem_rdata
                        : f3_q[0] ? {{16{!f3_q[2] && lh[15]}}, lh}
                        : {{24{!f3_q[2] && lb[7]}}, lb};
   end
   always_ff @(posedge clk_Mem) begin
      if (!rst_Mem) begin
         state <= IDLE;
         cnt <= 8'h0;
         dmem_req <= 1'b0;
         dmem_we <= 1'b0;
         dmem_addr <= 32'h0;
         dmem_be <= 4'h0;
         dmem_wdata <= 32'h0;
         f3_q <= 3'b000;
         a_q <= 2'b00;
         misalign_Mem <= 1'b0;
         bus_err_Mem <= 1'b0;
      end else begin
         state <= state_n;
         misalign_Mem <= bad;
         bus_err_Mem <= tmo;
         if (issue) begin
            dmem_req <= 1'b1;
            dmem_we <= MemWrite_in_Mem;
            dmem_addr <= {ALU_in_Mem[31:2], 2'b00};
            dmem_be <= !MemWrite_in_Mem ? 4'b1111 : is_byte ? 4'b0001 << ALU_in_Mem[1:0]
                     : is_half ? (ALU_in_Mem[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            dmem_wdata <= is_byte ? {4{Rs2_data_in_Mem[7:0]}}
                        : is_half ? {2{Rs2_data_in_Mem[15:0]}} : Rs2_data_in_Mem;
            f3_q <= funct3_in_Mem;
            a_q <= ALU_in_Mem[1:0];
            cnt <= 8'h0;
         end else if (ack || tmo) begin
            dmem_req <= 1'b0;
         end else if (state == WAIT) begin
            cnt <= cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed checks of mem_access_stage against a transaction-level model
module tb_mem_access_stage;
   localparam int TIMEOUT = 4;
   logic        clk = 0, rst = 0, valid = 0, mr = 0, mw = 0, rw = 0, ack = 0;
   logic [31:0] pc = 0, inst = 0, pc4 = 0, alu = 0, rs2 = 0, rdata = 0;
   logic [4:0]  rd = 0;
   logic [2:0]  f3 = 0;
   logic [1:0]  mtr = 0;
   logic        req, we, stall, misalign, bus_err, rw_o, valid_o;
   logic [31:0] addr, wdata, pc_o, inst_o, pc4_o, alu_o, data_o;
   logic [3:0]  be;
   logic [4:0]  rd_o;
   logic [1:0]  mtr_o;
   int total = 0, bad_cnt = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk_Mem(clk), .rst_Mem(rst), .valid_in_Mem(valid), .PC_in_Mem(pc), .inst_in_Mem(inst),
      .PC4_in_Mem(pc4), .Rd_addr_in_Mem(rd), .ALU_in_Mem(alu), .Rs2_data_in_Mem(rs2),
      .MemRead_in_Mem(mr), .MemWrite_in_Mem(mw), .funct3_in_Mem(f3), .MemtoReg_in_Mem(mtr),
      .RegWrite_in_Mem(rw), .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_be(be),
      .dmem_wdata(wdata), .dmem_ack(ack), .dmem_rdata(rdata), .stall_Mem(stall),
      .misalign_Mem(misalign), .bus_err_Mem(bus_err), .PC_out_Mem(pc_o), .inst_out_Mem(inst_o),
      .PC4_out_Mem(pc4_o), .Rd_addr_out_Mem(rd_o), .ALU_out_Mem(alu_o), .MemtoReg_out_Mem(mtr_o),
      .Dmem_data_out_Mem(data_o), .RegWrite_out_Mem(rw_o), .valid_out_Mem(valid_o)
   );

   function automatic bit is_bad(bit st, logic [2:0] f, logic [31:0] a);
      bit legal;
      legal = st ? (f == 0 || f == 1 || f == 2) : (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
      return !legal || (f[1:0] == 1 && a % 2 != 0) || (f[1:0] == 2 && a % 4 != 0);
   endfunction

   function automatic logic [3:0] exp_be(bit st, logic [2:0] f, logic [1:0] a);
      if (!st || f[1:0] == 2) return 4'hF;
      if (f[1:0] == 0) return 4'(1 << a);
      return (a >= 2) ? 4'hC : 4'h3;
   endfunction

   function automatic logic [31:0] exp_wdata(logic [2:0] f, logic [31:0] r);
      if (f[1:0] == 0) return (r & 32'hFF) * 32'h01010101;
      if (f[1:0] == 1) return (r & 32'hFFFF) * 32'h00010001;
      return r;
   endfunction

   function automatic logic [31:0] exp_load(logic [2:0] f, logic [1:0] a, logic [31:0] w);
      logic [31:0] v;
      if (f[1:0] == 2) return w;
      if (f[1:0] == 0) begin
         v = (w >> (8 * a)) & 32'hFF;
         if (f == 0 && v >= 128) v = v - 256;
      end else begin
         v = (w >> (16 * (a / 2))) & 32'hFFFF;
         if (f == 1 && v >= 32768) v = v - 65536;
      end
      return v;
   endfunction

   // One complete access: issue cycle, WAIT cycles, then ack after dly stalled cycles or abort on timeout.
   task automatic do_access(string nm, bit st, logic [2:0] f, logic [31:0] a, logic [31:0] r2,
                            logic [31:0] rword, int dly, bit rwv);
      bit timed_out = 0;
      @(negedge clk);
      valid = 1; mr = !st; mw = st; f3 = f; alu = a; rs2 = r2; rw = rwv; ack = 0;
      pc = $urandom; inst = $urandom; pc4 = pc + 4; rd = 5'($urandom);
      #2;
      total++;
      if ({stall, valid_o, rw_o, req, misalign, bus_err} !== 6'b100000) begin
         bad_cnt++;
         $display("FAIL %s issue: stall/valid/rw/req/mis/berr=%b want 100000", nm, {stall, valid_o, rw_o, req, misalign, bus_err});
      end
      for (int w = 0; w <= TIMEOUT; w++) begin
         @(negedge clk);
         ack = (w == dly);
         rdata = (w == dly) ? rword : $urandom;
         #2;
         total++;
         if ({req, we, addr, be, wdata} !== {1'b1, st, a & ~32'h3, exp_be(st, f, a[1:0]), st ? exp_wdata(f, r2) : wdata}) begin
            bad_cnt++;
            $display("FAIL %s wait%0d bus: req=%b we=%b addr=%h be=%b wdata=%h want we=%b addr=%h be=%b wdata=%h",
                     nm, w, req, we, addr, be, wdata, st, a & ~32'h3, exp_be(st, f, a[1:0]), exp_wdata(f, r2));
         end
         if (w == dly) begin
            total++;
            if ({stall, valid_o, rw_o} !== {2'b01, rwv} || (!st && data_o !== exp_load(f, a[1:0], rword))) begin
               bad_cnt++;
               $display("FAIL %s ack: stall/valid/rw=%b data=%h want %b data=%h", nm, {stall, valid_o, rw_o},
                        data_o, {2'b01, rwv}, exp_load(f, a[1:0], rword));
            end
            break;
         end else if (w == TIMEOUT - 1) begin
            total++;
            if ({stall, valid_o, rw_o, data_o} !== 35'h0) begin
               bad_cnt++;
               $display("FAIL %s abort: stall/valid/rw=%b data=%h want 000 0", nm, {stall, valid_o, rw_o}, data_o);
            end
            timed_out = 1;
            break;
         end else begin
            total++;
            if ({stall, valid_o, rw_o, data_o} !== {3'b100, 32'h0}) begin
               bad_cnt++;
               $display("FAIL %s stall%0d: stall/valid/rw=%b data=%h want 100 0", nm, w, {stall, valid_o, rw_o}, data_o);
            end
         end
      end
      if (timed_out) begin
         @(negedge clk);
         valid = 0; mr = 0; mw = 0; ack = 0;
         #2;
         total++;
         if ({req, bus_err, stall} !== 3'b010) begin
            bad_cnt++;
            $display("FAIL %s after_abort: req/berr/stall=%b want 010", nm, {req, bus_err, stall});
         end
      end
   endtask

   task automatic test_passthrough();
      @(negedge clk);
      valid = 1'($urandom); mr = 0; mw = 0; ack = 0; rw = 1'($urandom);
      pc = $urandom; inst = $urandom; pc4 = $urandom; rd = 5'($urandom); alu = $urandom; mtr = 2'($urandom);
      #2;
      total++;
      if ({pc_o, inst_o, pc4_o, rd_o, alu_o, mtr_o, valid_o, rw_o, stall, data_o} !==
          {pc, inst, pc4, rd, alu, mtr, valid, rw, 1'b0, 32'h0}) begin
         bad_cnt++;
         $display("FAIL passthrough: pc=%h inst=%h alu=%h valid=%b rw=%b stall=%b data=%h want pc=%h inst=%h alu=%h valid=%b rw=%b",
                  pc_o, inst_o, alu_o, valid_o, rw_o, stall, data_o, pc, inst, alu, valid, rw);
      end
   endtask

   task automatic test_misalign(string nm, bit st, logic [2:0] f, logic [31:0] a);
      @(negedge clk);
      valid = 1; mr = !st; mw = st; f3 = f; alu = a; rw = 1; ack = 0;
      #2;
      total++;
      if ({stall, valid_o, rw_o} !== 3'b000) begin
         bad_cnt++;
         $display("FAIL %s cycle: stall/valid/rw=%b want 000", nm, {stall, valid_o, rw_o});
      end
      @(negedge clk);
      valid = 0; mr = 0; mw = 0;
      #2;
      total++;
      if ({misalign, req} !== 2'b10) begin
         bad_cnt++;
         $display("FAIL %s pulse: misalign/req=%b want 10", nm, {misalign, req});
      end
      @(negedge clk);
      #2;
      total++;
      if (misalign !== 1'b0) begin
         bad_cnt++;
         $display("FAIL %s pulse_end: misalign=%b want 0", nm, misalign);
      end
   endtask

   task automatic test_reset();
      rst = 0; ack = 0; valid = 0;
      repeat (2) @(negedge clk);
      #2;
      total++;
      if ({req, we, addr, be, wdata, stall, misalign, bus_err} !== 73'h0) begin
         bad_cnt++;
         $display("FAIL reset: req=%b we=%b addr=%h be=%b wdata=%h stall=%b mis=%b berr=%b want all 0",
                  req, we, addr, be, wdata, stall, misalign, bus_err);
      end
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_loads();
      do_access("lb", 0, 3'b000, 32'h103, 0, 32'h80FF1234, 1, 1);
      do_access("lbu", 0, 3'b100, 32'h103, 0, 32'h80FF1234, 0, 1);
      do_access("lhu", 0, 3'b101, 32'h102, 0, 32'h80FF1234, 2, 1);
      do_access("lh", 0, 3'b001, 32'h102, 0, 32'h80FF1234, 0, 0);
   endtask

   task automatic test_back_to_back();
      do_access("b2b_a", 0, 3'b010, 32'h40, 0, 32'h12345678, 0, 1);
      do_access("b2b_b", 1, 3'b000, 32'h41, 32'h5A, 0, 0, 0);
      do_access("b2b_c", 0, 3'b000, 32'h41, 0, 32'h00007F00, 0, 1);
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      valid = 1; mr = 1; mw = 0; f3 = 3'b010; alu = 32'h200; rw = 1; ack = 0;
      @(negedge clk);
      #2;
      total++;
      if ({req, stall} !== 2'b11) begin
         bad_cnt++;
         $display("FAIL rst_wait pre: req/stall=%b want 11", {req, stall});
      end
      @(negedge clk);
      rst = 0; valid = 0; mr = 0;
      @(negedge clk);
      rst = 1; ack = 1; rdata = 32'hCAFEF00D;
      #2;
      total++;
      if ({req, valid_o, stall, data_o} !== 35'h0) begin
         bad_cnt++;
         $display("FAIL rst_wait late_ack: req=%b valid=%b stall=%b data=%h want 0 0 0 0", req, valid_o, stall, data_o);
      end
      @(negedge clk);
      ack = 0;
      #2;
      total++;
      if ({req, bus_err, valid_o} !== 3'b000) begin
         bad_cnt++;
         $display("FAIL rst_wait after: req/berr/valid=%b want 000", {req, bus_err, valid_o});
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [2:0] f;
      bit st;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 2))
            0: test_passthrough();
            1: begin
               st = 1'($urandom);
               do begin
                  f = 3'($urandom);
                  a = $urandom;
               end while (is_bad(st, f, a));
               do_access("rand_acc", st, f, a, $urandom, $urandom, $urandom_range(0, TIMEOUT + 1), 1'($urandom));
            end
            default: begin
               st = 1'($urandom);
               do begin
                  f = 3'($urandom);
                  a = $urandom;
               end while (!is_bad(st, f, a));
               test_misalign("rand_bad", st, f, a);
            end
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      do_access("sw", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 3, 0);
      test_loads();
      do_access("sh", 1, 3'b001, 32'h102, 32'h0000ABCD, 0, 1, 0);
      test_misalign("lw_mis", 0, 3'b010, 32'h101);
      test_misalign("sh_odd", 1, 3'b001, 32'h203);
      test_misalign("ld_f3_011", 0, 3'b011, 32'h300);
      test_misalign("st_f3_100", 1, 3'b100, 32'h300);
      do_access("timeout", 0, 3'b010, 32'h180, 0, 0, TIMEOUT + 2, 1);
      test_back_to_back();
      test_reset_mid_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad_cnt);
      $finish;
   end
endmodule
